uart_tx_fifo: RTL and testbench

Parametrised successor to the fixed 8N1 UART transmitter used by the jpu console path. Accepts words on a valid/ready interface into an internal FIFO. Serialises each word LSB-first with a configurable data width, parity mode and stop-bit count. Sits between the core's MMIO console register and the board TX pin, and doubles as the host-side stimulus driver in benches.

---
 rtl/uart_tx_fifo_pkg.sv | 26 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART types and constants for the jpu console path.
// Imported by the transmitter and its FIFO.
package jpu;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } uart_parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_e;

  localparam int unsigned UART_CLKS_115200_100MHZ = 868;

  // Parity bit sent on the line, given the XOR of all data bits.
  function automatic logic uart_parity_bit(input uart_parity_e mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with an occupancy count, asynchronous active-low reset.
// Shared by the UART transmitter and the planned receiver.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers alone cannot tell full from empty; the count decides.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready word intake, configurable data width,
// parity and stop bits, LSB-first serialisation on a registered tx line.
module uart_tx_fifo
  import jpu::*;
#(
  parameter int                DATA_BITS    = 8,
  parameter jpu::uart_parity_e PARITY       = jpu::PAR_NONE,
  parameter int                STOP_BITS    = 1,
  parameter int                CLKS_PER_BIT = 868,
  parameter int                FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
  end

  localparam int BAUD_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

  uart_tx_state_e         state_q;
  logic [BAUD_W-1:0]      baud_q;
  logic [BIT_W-1:0]       bit_idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   tx_q;

  logic [DATA_BITS-1:0]   fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   baud_done;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_done = (baud_q == '0);
  // Popping at the end of STOP chains the next start bit with no idle gap.
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == ST_IDLE) || (state_q == ST_STOP && baud_done));

  assign tx_ready = !fifo_full;
  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else if (fifo_pop) begin
      state_q   <= ST_START;
      baud_q    <= BIT_LAST;
      bit_idx_q <= '0;
      shift_q   <= fifo_dout;
      par_q     <= uart_parity_bit(PARITY, ^fifo_dout);
      tx_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
        end
        ST_START: begin
          if (!baud_done) begin
            baud_q <= baud_q - BAUD_W'(1);
          end else begin
            state_q <= ST_DATA;
            baud_q  <= BIT_LAST;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        ST_DATA: begin
          if (!baud_done) begin
            baud_q <= baud_q - BAUD_W'(1);
          end else if (bit_idx_q != DATA_LAST) begin
            bit_idx_q <= bit_idx_q + BIT_W'(1);
            baud_q    <= BIT_LAST;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end else if (PARITY != PAR_NONE) begin
            state_q <= ST_PARITY;
            baud_q  <= BIT_LAST;
            tx_q    <= par_q;
          end else begin
            state_q <= ST_STOP;
            baud_q  <= STOP_LAST;
            tx_q    <= 1'b1;
          end
        end
        ST_PARITY: begin
          if (!baud_done) begin
            baud_q <= baud_q - BAUD_W'(1);
          end else begin
            state_q <= ST_STOP;
            baud_q  <= STOP_LAST;
            tx_q    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (!baud_done) begin
            baud_q <= baud_q - BAUD_W'(1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8E1, 7O2, 9N1) driven with random
// words and decoded by a line-level frame model with a word scoreboard.
module tb_uart_tx_fifo;
  import jpu::*;

  localparam int NI    = 3;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  typedef logic [8:0] word_t;

  function automatic int db_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 7 : 9);
  endfunction

  function automatic uart_parity_e par_of(input int k);
    return (k == 0) ? PAR_EVEN : ((k == 1) ? PAR_ODD : PAR_NONE);
  endfunction

  function automatic int sb_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int flen(input int k);
    return CPB * (1 + db_of(k) + ((par_of(k) != PAR_NONE) ? 1 : 0) + sb_of(k));
  endfunction

  function automatic word_t directed_word(input int k);
    return (k == 0) ? 9'h041 : ((k == 1) ? 9'h000 : 9'h1FF);
  endfunction

  // Line level of bit slot p of a frame carrying word w.
  function automatic int exp_bit(input int k, input word_t w, input int p);
    int db;
    int ones;
    db = db_of(k);
    if (p == 0) return 0;
    if (p <= db) return int'(w[p-1]);
    if (par_of(k) != PAR_NONE && p == db + 1) begin
      ones = $countones(w);
      return (par_of(k) == PAR_EVEN) ? (ones % 2) : (1 - ones % 2);
    end
    return 1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       tx_a   [NI];
  logic       rdy_a  [NI];
  logic       busy_a [NI];
  logic       rst_a  [NI];
  logic       vld_a  [NI];
  logic       tmo_a  [NI];
  logic [2:0] cnt_a  [NI];
  word_t      din_a  [NI];

  for (genvar k = 0; k < NI; k++) begin : g
    localparam int DB = db_of(k);

    logic          rst_n;
    logic          vld;
    logic [DB-1:0] dat;
    logic          tx;
    logic          rdy;
    logic          busy;
    logic [2:0]    cnt;
    logic          tmo;
    logic          done;

    uart_tx_fifo #(
      .DATA_BITS    (DB),
      .PARITY       (par_of(k)),
      .STOP_BITS    (sb_of(k)),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (dat),
      .tx_valid   (vld),
      .tx_ready   (rdy),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (cnt)
    );

    assign tx_a[k]   = tx;
    assign rdy_a[k]  = rdy;
    assign busy_a[k] = busy;
    assign rst_a[k]  = rst_n;
    assign vld_a[k]  = vld;
    assign tmo_a[k]  = tmo;
    assign cnt_a[k]  = cnt;
    assign din_a[k]  = 9'(dat);

    // Offers n words; tx_data is re-randomised every cycle until a word is taken.
    task automatic send(input int n, input int gap_max, input bit fixed, input logic [DB-1:0] fw);
      bit acc;
      int w;
      for (int i = 0; i < n; i++) begin
        acc = 1'b0;
        w   = 0;
        while (!acc) begin
          vld = 1'b1;
          dat = fixed ? fw : DB'($urandom);
          acc = rdy;
          @(posedge clk); #1;
          w++;
          if (w > 2000) begin
            tmo = 1'b1;
            acc = 1'b1;
          end
        end
        vld = 1'b0;
        repeat ($urandom_range(gap_max, 0)) begin
          @(posedge clk); #1;
        end
      end
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      repeat (2) begin @(posedge clk); #1; end
      while (busy && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      if (busy) tmo = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
      rst_n = 1'b1;
      vld   = 1'b0;
      dat   = '0;
      tmo   = 1'b0;
      done  = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end

      send(1, 0, 1'b1, DB'(directed_word(k)));
      wait_idle();

      send(6, 0, 1'b0, '0);
      wait_idle();

      send(25, 3, 1'b0, '0);
      wait_idle();

      send(3, 0, 1'b0, '0);
      repeat (12) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      repeat (3 * flen(k)) begin @(posedge clk); #1; end

      done = 1'b1;
    end
  end

  task automatic check(input int k, input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %0d expected %0d at %0t", k, nm, act, exp, $time);
    end
  endtask

  word_t expq  [NI][$];
  word_t cur   [NI];
  word_t wd    [NI];
  int    cyc   [NI];
  int    pprev [NI];
  bit    inf   [NI];
  bit    lat   [NI];
  bit    will  [NI];

  // Line-level monitor: decodes frames, pops the scoreboard, checks flags every cycle.
  always @(negedge clk) begin
    int  pb;
    bit  acc;
    for (int k = 0; k < NI; k++) begin
      if (!rst_a[k]) begin
        check(k, "rst_tx", int'(tx_a[k]), 1);
        check(k, "rst_ready", int'(rdy_a[k]), 1);
        check(k, "rst_busy", int'(busy_a[k]), 0);
        check(k, "rst_count", int'(cnt_a[k]), 0);
        expq[k].delete();
        inf[k]   = 1'b0;
        lat[k]   = 1'b0;
        will[k]  = 1'b0;
        pprev[k] = 0;
        cyc[k]   = 0;
      end else begin
        pb  = expq[k].size();
        acc = will[k];
        if (acc) expq[k].push_back(wd[k]);
        if (lat[k]) begin
          check(k, "start_latency", int'(tx_a[k]), 0);
          lat[k] = 1'b0;
        end
        if (inf[k]) begin
          cyc[k]++;
          if (cyc[k] == flen(k)) begin
            inf[k] = 1'b0;
            if (pprev[k] > 0) check(k, "no_gap", int'(tx_a[k]), 0);
          end
        end
        if (!inf[k] && tx_a[k] === 1'b0) begin
          inf[k] = 1'b1;
          cyc[k] = 0;
          check(k, "frame_has_word", int'(expq[k].size() != 0), 1);
          cur[k] = (expq[k].size() != 0) ? expq[k].pop_front() : '0;
        end
        if (inf[k]) check(k, "tx_bit", int'(tx_a[k]), exp_bit(k, cur[k], cyc[k] / CPB));
        else        check(k, "tx_idle", int'(tx_a[k]), 1);
        if (acc && pb == 0 && !inf[k]) lat[k] = 1'b1;
        check(k, "fifo_count", int'(cnt_a[k]), expq[k].size());
        check(k, "tx_ready", int'(rdy_a[k]), int'(expq[k].size() < DEPTH));
        check(k, "busy", int'(busy_a[k]), int'(inf[k] || expq[k].size() != 0));
        check(k, "stim_timeout", int'(tmo_a[k]), 0);
        pprev[k] = expq[k].size();
        will[k]  = vld_a[k] && rdy_a[k];
        wd[k]    = din_a[k];
      end
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int i = 0; i < 40000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g[0].done && g[1].done && g[2].done;
    end
    if (!all_done) begin
      $display("FAIL global_timeout: stimulus still running, errors so far %0d", errors);
      $fatal(1, "global timeout");
    end
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
